// File: rtl/snake_tail.sv
// snake_tail: circular FIFO of head cells; once the target length is reached each step retires the oldest cell as an erase.
// Defining SNAKE_TAIL_PEEK_EN adds registered tail_valid/tail_x/tail_y outputs exposing the oldest stored cell.
module snake_tail #(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned INIT_LEN = 3,
  parameter int unsigned XW       = 6,
  parameter int unsigned YW       = 6
) (
  input  logic                   clk_pix,
  input  logic                   rst_pix,
  input  logic                   step,
  input  logic [XW-1:0]          head_x,
  input  logic [YW-1:0]          head_y,
  input  logic                   grow,
  input  logic                   clear,
  output logic                   erase_valid,
  output logic [XW-1:0]          erase_x,
  output logic [YW-1:0]          erase_y,
  output logic [$clog2(DEPTH):0] length,
  output logic                   full
`ifdef SNAKE_TAIL_PEEK_EN
  ,
  output logic                   tail_valid,
  output logic [XW-1:0]          tail_x,
  output logic [YW-1:0]          tail_y
`endif
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam int unsigned CW = XW + YW;

  logic [CW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [LW-1:0] len_tgt;
  logic          erase_q;

  logic          pop_c;
  logic [CW-1:0] cell_c;
  logic [PW-1:0] rd_nxt_c;
  logic [LW-1:0] length_nxt_c;

  // Pop decision uses len_tgt before any same-cycle grow.
  always_comb begin
    pop_c        = 1'b0;
    cell_c       = {head_x, head_y};
    rd_nxt_c     = rd_ptr;
    length_nxt_c = length;
    if (step) begin
      pop_c = (length >= len_tgt);
      if (pop_c) rd_nxt_c = rd_ptr + PW'(1);
      else       length_nxt_c = length + LW'(1);
    end
  end

  // Trail storage; contents are don't-care until written.
  always_ff @(posedge clk_pix) begin
    if (step && !clear && !rst_pix) mem[wr_ptr] <= cell_c;
  end

  always_ff @(posedge clk_pix) begin
    if (rst_pix) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      length  <= '0;
      full    <= 1'b0;
      len_tgt <= LW'(INIT_LEN);
      erase_q <= 1'b0;
      erase_x <= '0;
      erase_y <= '0;
    end else if (clear) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      length  <= '0;
      full    <= 1'b0;
      len_tgt <= LW'(INIT_LEN);
      erase_q <= 1'b0;
    end else begin
      erase_q <= pop_c;
      if (pop_c) {erase_x, erase_y} <= mem[rd_ptr];
      if (step) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_nxt_c;
      length <= length_nxt_c;
      full   <= (length_nxt_c == LW'(DEPTH));
      if (grow && (len_tgt != LW'(DEPTH))) len_tgt <= len_tgt + LW'(1);
    end
  end

  // A reset arriving while an erase is outstanding must cancel it immediately.
  assign erase_valid = erase_q && !rst_pix;

`ifdef SNAKE_TAIL_PEEK_EN
  // Oldest cell after this step: the fresh head when the FIFO was empty, else the entry at the new read pointer.
  always_ff @(posedge clk_pix) begin
    if (rst_pix || clear) begin
      tail_valid <= 1'b0;
      tail_x     <= '0;
      tail_y     <= '0;
    end else if (step) begin
      tail_valid <= 1'b1;
      {tail_x, tail_y} <= (rd_nxt_c == wr_ptr) ? cell_c : mem[rd_nxt_c];
    end
  end
`endif

endmodule

// File: tb/tb_snake_tail.sv
// Self-checking bench for snake_tail: directed table, reset-during-erase sequence,
// randomized run against a queue model, and a DEPTH=4 saturation/wrap run.
module tb_snake_tail;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, step, grow, clear;
  logic [5:0] hx, hy;
  logic       ev;
  logic [5:0] ex, ey;
  logic [8:0] len;
  logic       full;

  logic       s_rst, s_step, s_grow, s_clear;
  logic [5:0] s_hx, s_hy;
  logic       s_ev;
  logic [5:0] s_ex, s_ey;
  logic [2:0] s_len;
  logic       s_full;
`ifdef SNAKE_TAIL_PEEK_EN
  logic       tv, s_tv;
  logic [5:0] tx, ty, s_tx, s_ty;
`endif

  snake_tail u_dut (
    .clk_pix(clk), .rst_pix(rst), .step(step), .head_x(hx), .head_y(hy),
    .grow(grow), .clear(clear), .erase_valid(ev), .erase_x(ex), .erase_y(ey),
    .length(len), .full(full)
`ifdef SNAKE_TAIL_PEEK_EN
    , .tail_valid(tv), .tail_x(tx), .tail_y(ty)
`endif
  );

  snake_tail #(.DEPTH(4), .INIT_LEN(4)) u_small (
    .clk_pix(clk), .rst_pix(s_rst), .step(s_step), .head_x(s_hx), .head_y(s_hy),
    .grow(s_grow), .clear(s_clear), .erase_valid(s_ev), .erase_x(s_ex), .erase_y(s_ey),
    .length(s_len), .full(s_full)
`ifdef SNAKE_TAIL_PEEK_EN
    , .tail_valid(s_tv), .tail_x(s_tx), .tail_y(s_ty)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: the trail is a queue of cells, oldest first.
  logic [11:0] mq[$];
  int          tgt;
  logic        m_ev;
  logic [5:0]  m_ex, m_ey;
  logic        m_tv;
  logic [11:0] m_tail;

  task automatic model_apply(input bit r, input bit c, input bit s, input bit g,
                             input logic [5:0] x, input logic [5:0] y);
    m_ev = 1'b0;
    if (r || c) begin
      mq.delete();
      tgt = 3;
      m_tail = '0;
      if (r) begin m_ex = '0; m_ey = '0; end
    end else begin
      if (s) begin
        if (mq.size() >= tgt) begin
          {m_ex, m_ey} = mq.pop_front();
          m_ev = 1'b1;
        end
        mq.push_back({x, y});
      end
      if (g && tgt < 256) tgt++;
    end
    m_tv = (mq.size() > 0);
    if (mq.size() > 0) m_tail = mq[0];
  endtask

  task automatic check_main(input string tag);
    chk({tag, ".erase_valid"}, 32'(ev), 32'(m_ev));
    chk({tag, ".erase_xy"}, 32'({ex, ey}), 32'({m_ex, m_ey}));
    chk({tag, ".length"}, 32'(len), 32'(mq.size()));
    chk({tag, ".full"}, 32'(full), 32'(mq.size() == 256));
`ifdef SNAKE_TAIL_PEEK_EN
    chk({tag, ".tail_valid"}, 32'(tv), 32'(m_tv));
    chk({tag, ".tail_xy"}, 32'({tx, ty}), 32'(m_tail));
`endif
  endtask

  task automatic drive(input bit r, input bit c, input bit s, input bit g,
                       input logic [5:0] x, input logic [5:0] y, input string tag);
    rst = r; clear = c; step = s; grow = g; hx = x; hy = y;
    model_apply(r, c, s, g, x, y);
    @(posedge clk); @(negedge clk);
    check_main(tag);
  endtask

  typedef struct {
    bit s, g, c;
    logic [5:0] x, y;
    bit ev;
    logic [5:0] ex, ey;
    int len;
    bit tv;
    logic [5:0] tx, ty;
  } vec_t;

  function automatic vec_t mk(input bit s, input bit g, input bit c, input int x, input int y,
                              input bit e, input int exx, input int eyy, input int ln,
                              input bit t, input int txx, input int tyy);
    vec_t v;
    v.s = s; v.g = g; v.c = c; v.x = 6'(x); v.y = 6'(y);
    v.ev = e; v.ex = 6'(exx); v.ey = 6'(eyy); v.len = ln;
    v.tv = t; v.tx = 6'(txx); v.ty = 6'(tyy);
    return v;
  endfunction

  vec_t vt[15];
  logic [11:0] pushed[301];

  initial begin
    rst = 1'b1; step = 0; grow = 0; clear = 0; hx = '0; hy = '0;
    s_rst = 1'b1; s_step = 0; s_grow = 0; s_clear = 0; s_hx = '0; s_hy = '0;
    m_ex = '0; m_ey = '0; tgt = 3;
    model_apply(1, 0, 0, 0, '0, '0);

    //        s g c   x  y  ev ex ey len tv tx ty
    vt[0]  = mk(1,0,0,  5,24, 0, 0, 0, 1, 1, 5,24);
    vt[1]  = mk(1,0,0,  6,24, 0, 0, 0, 2, 1, 5,24);
    vt[2]  = mk(1,0,0,  7,24, 0, 0, 0, 3, 1, 5,24);
    vt[3]  = mk(1,0,0,  8,24, 1, 5,24, 3, 1, 6,24);
    vt[4]  = mk(1,1,0,  9,24, 1, 6,24, 3, 1, 7,24);
    vt[5]  = mk(1,0,0, 10,24, 0, 6,24, 4, 1, 7,24);
    vt[6]  = mk(1,1,1, 11,24, 0, 6,24, 0, 0, 0, 0);
    vt[7]  = mk(1,0,0,  1, 1, 0, 6,24, 1, 1, 1, 1);
    vt[8]  = mk(1,0,0,  2, 2, 0, 6,24, 2, 1, 1, 1);
    vt[9]  = mk(1,0,0,  3, 3, 0, 6,24, 3, 1, 1, 1);
    vt[10] = mk(1,0,0,  4, 4, 1, 1, 1, 3, 1, 2, 2);
    vt[11] = mk(1,0,1,  9, 9, 0, 1, 1, 0, 0, 0, 0);
    vt[12] = mk(1,0,0, 12, 1, 0, 1, 1, 1, 1,12, 1);
    vt[13] = mk(1,0,0, 13, 2, 0, 1, 1, 2, 1,12, 1);
    vt[14] = mk(1,0,0, 14, 3, 0, 1, 1, 3, 1,12, 1);

    repeat (2) @(negedge clk);
    check_main("reset");
    chk("small_reset.length", 32'(s_len), 32'd0);
    chk("small_reset.erase_valid", 32'(s_ev), 32'd0);
    rst = 1'b0; s_rst = 1'b0;

    // Directed table
    for (int i = 0; i < 15; i++) begin
      step = vt[i].s; grow = vt[i].g; clear = vt[i].c; hx = vt[i].x; hy = vt[i].y;
      model_apply(0, vt[i].c, vt[i].s, vt[i].g, vt[i].x, vt[i].y);
      @(posedge clk); @(negedge clk);
      chk($sformatf("vec%0d.erase_valid", i), 32'(ev), 32'(vt[i].ev));
      chk($sformatf("vec%0d.erase_xy", i), 32'({ex, ey}), 32'({vt[i].ex, vt[i].ey}));
      chk($sformatf("vec%0d.length", i), 32'(len), 32'(vt[i].len));
      chk($sformatf("vec%0d.full", i), 32'(full), 32'd0);
`ifdef SNAKE_TAIL_PEEK_EN
      chk($sformatf("vec%0d.tail_valid", i), 32'(tv), 32'(vt[i].tv));
      chk($sformatf("vec%0d.tail_xy", i), 32'({tx, ty}), 32'({vt[i].tx, vt[i].ty}));
`endif
    end
    step = 0; grow = 0; clear = 0;

    // Reset raised in the cycle right after a popping step
    step = 1; hx = 6'd7; hy = 6'd7;
    model_apply(0, 0, 1, 0, 6'd7, 6'd7);
    @(posedge clk); #1;
    step = 0; rst = 1'b1;
    #1 chk("rst_suppress.erase_valid", 32'(ev), 32'd0);
    @(posedge clk); #1;
    model_apply(1, 0, 0, 0, '0, '0);
    check_main("after_rst");
    @(negedge clk);
    rst = 1'b0;

    // Randomized run against the queue model
    for (int n = 0; n < 3000; n++) begin
      drive(($urandom % 1500) == 0, ($urandom % 1000) == 0, ($urandom % 2) == 1,
            ($urandom % 8) == 0, 6'($urandom), 6'($urandom), $sformatf("rnd%0d", n));
    end
    rst = 0; clear = 0; step = 0; grow = 0;

    // DEPTH=4 instance: saturate target, then wrap pointers many times
    s_grow = 1'b1;
    repeat (10) @(negedge clk);
    s_grow = 1'b0;
    @(negedge clk);
    chk("small_grow.length", 32'(s_len), 32'd0);
    for (int k = 1; k <= 300; k++) begin
      pushed[k] = 12'($urandom);
      s_step = 1'b1; {s_hx, s_hy} = pushed[k];
      @(posedge clk); @(negedge clk);
      chk($sformatf("small%0d.length", k), 32'(s_len), 32'((k < 4) ? k : 4));
      chk($sformatf("small%0d.full", k), 32'(s_full), 32'(k >= 4));
      chk($sformatf("small%0d.erase_valid", k), 32'(s_ev), 32'(k >= 5));
      if (k >= 5) chk($sformatf("small%0d.erase_xy", k), 32'({s_ex, s_ey}), 32'(pushed[k-4]));
`ifdef SNAKE_TAIL_PEEK_EN
      chk($sformatf("small%0d.tail_xy", k), 32'({s_tx, s_ty}), 32'(pushed[(k > 4) ? k - 3 : 1]));
`endif
    end
    s_step = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
